// File: rtl/hilo_mult_ctrl_pkg.sv
// Shared CPU definitions: R-type funct codes for the Hi/Lo unit and the
// multiplier FSM state encoding. Decode and writeback-select logic import
// the same constants so every stage agrees on them.
package hilo_mult_ctrl_pkg;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

    // True for any instruction that touches Hi/Lo and therefore has to wait
    // for an in-flight multiplication.
    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f == FUNCT_MULTU) || (f == FUNCT_MFHI) || (f == FUNCT_MFLO);
    endfunction

endpackage

// File: rtl/hilo_shift_add.sv
// Shift-add datapath for the unsigned multiplier: holds the multiplicand,
// the multiplier (shifted right once per step) and the 2*WIDTH partial
// product. The add carry is shifted straight into the product MSB, so the
// carry lives in the partial-product register between steps.
module hilo_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   prod_next
);

    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [WIDTH:0]     sum;

    // One shift-add step: conditional add into the upper half, then shift
    // {carry, product} right by one.
    always_comb begin
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_next = {sum, prod_q[WIDTH-1:1]};
    end

    // Next-state for the datapath registers: load clears, step advances.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (load) begin
            mcand_d  = mcand_in;
            mplier_d = mplier_in;
            prod_d   = '0;
        end else if (step) begin
            mplier_d = mplier_q >> 1;
            prod_d   = prod_next;
        end
    end

    // Datapath register bank.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are plain flops, not RAM, so they can and do take the reset; a partial product never survives a reset.
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Hi/Lo multiply controller: accepts MULTU from EX, runs a WIDTH-cycle
// shift-add multiplication, commits the product to Hi/Lo on the last step
// and stalls any Hi/Lo instruction issued while the multiply is in flight.
module hilo_mult_ctrl
    import hilo_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // The counter exits MUL at WIDTH-1, so it never needs to hold WIDTH.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               dp_load;
    logic               dp_step;
    logic [2*WIDTH-1:0] prod_next;

    hilo_shift_add #(
        .WIDTH (WIDTH)
    ) u_shift_add (
        .clk       (clk),
        .rst       (rst),
        .load      (dp_load),
        .step      (dp_step),
        .mcand_in  (rs_data),
        .mplier_in (rt_data),
        .prod_next (prod_next)
    );

    // FSM next state, counter, Hi/Lo commit and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (issue_valid && (funct == FUNCT_MULTU)) begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                    dp_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                dp_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Last step: the stepped product is the final result.
                    hi_d    = prod_next[2*WIDTH-1:WIDTH];
                    lo_d    = prod_next[WIDTH-1:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and architectural Hi/Lo registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Status outputs; stall is combinational so the front end holds in the
    // same cycle a Hi/Lo instruction meets a busy multiplier.
    always_comb begin
        busy   = (state_q == ST_MUL);
        done   = (state_q == ST_DONE);
        stall  = issue_valid && (state_q == ST_MUL) && is_hilo_funct(funct);
        hi_out = hi_q;
        lo_out = lo_q;
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl: table of known products, directed
// multi-cycle corner cases (stall, back-to-back MULTU, reset abort) and
// randomized operands checked against a plain 64-bit multiply model.
module tb_hilo_mult_ctrl;
    import hilo_mult_ctrl_pkg::*;

    localparam int MUL_CYCLES = 32;
    localparam int DONE_CYCLE = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks   = 0;
    int failures = 0;

    // Architectural Hi/Lo as the model expects them.
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    logic [5:0] noise_pool [5];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [7];

    hilo_mult_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Issue one MULTU and follow it to completion.
    // mode 0: quiet bus; 1: random non-MULTU traffic; 2: ADD held;
    // 3: MFHI held from MUL cycle 5 onward.
    task automatic run_mult(input string name, input logic [31:0] a,
                            input logic [31:0] b, input int mode);
        logic [63:0] exp_prod;
        logic        exp_stall;
        int          cycle;
        int          done_cycle;
        exp_prod = {32'd0, a} * {32'd0, b};
        issue_valid = 1'b1;
        funct       = FUNCT_MULTU;
        rs_data     = a;
        rt_data     = b;
        tick();
        issue_valid = 1'b0;
        funct       = 6'h00;
        rs_data     = $urandom;
        rt_data     = $urandom;
        cycle       = 1;
        done_cycle  = -1;
        check({name, " busy_cycle1"}, 64'(busy), 64'(1));
        while (cycle <= 40) begin
            case (mode)
                1: begin
                    issue_valid = 1'($urandom_range(0, 1));
                    funct       = noise_pool[$urandom_range(0, 4)];
                end
                2: begin
                    issue_valid = 1'b1;
                    funct       = 6'h20;
                end
                3: begin
                    issue_valid = (cycle >= 5);
                    funct       = FUNCT_MFHI;
                end
                default: issue_valid = 1'b0;
            endcase
            #1;
            if (mode != 0) begin
                exp_stall = issue_valid && (cycle <= MUL_CYCLES)
                          && (funct == FUNCT_MFHI || funct == FUNCT_MFLO);
                check($sformatf("%s stall_c%0d", name, cycle), 64'(stall), 64'(exp_stall));
            end
            if (done) begin
                done_cycle = cycle;
                break;
            end
            if (cycle == 16) begin
                check({name, " hi_held_mid"}, 64'(hi_out), 64'(model_hi));
                check({name, " lo_held_mid"}, 64'(lo_out), 64'(model_lo));
            end
            tick();
            cycle++;
        end
        check({name, " done_cycle"}, 64'(done_cycle), 64'(DONE_CYCLE));
        check({name, " hi"}, 64'(hi_out), 64'(exp_prod[63:32]));
        check({name, " lo"}, 64'(lo_out), 64'(exp_prod[31:0]));
        model_hi = exp_prod[63:32];
        model_lo = exp_prod[31:0];
        issue_valid = 1'b0;
        tick();
        check({name, " done_pulse_end"}, 64'(done), 64'(0));
        check({name, " busy_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;

        noise_pool = '{FUNCT_MFHI, FUNCT_MFLO, 6'h20, 6'h00, 6'h2a};
        vecs[0] = '{a: 32'd3,          b: 32'd5,          hi: 32'h0000_0000, lo: 32'h0000_000F};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
        vecs[2] = '{a: 32'd0,          b: 32'hDEAD_BEEF,  hi: 32'h0000_0000, lo: 32'h0000_0000};
        vecs[3] = '{a: 32'd1,          b: 32'hFFFF_FFFF,  hi: 32'h0000_0000, lo: 32'hFFFF_FFFF};
        vecs[4] = '{a: 32'h8000_0000,  b: 32'd2,          hi: 32'h0000_0001, lo: 32'h0000_0000};
        vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          hi: 32'h0000_0001, lo: 32'hFFFF_FFFE};
        vecs[6] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  hi: 32'h0000_0001, lo: 32'h0000_0000};

        // Reset state, with a Hi/Lo instruction on the bus.
        rst         = 1'b1;
        issue_valid = 1'b1;
        funct       = FUNCT_MFHI;
        rs_data     = '0;
        rt_data     = '0;
        tick();
        tick();
        check("reset busy",  64'(busy),   64'(0));
        check("reset done",  64'(done),   64'(0));
        check("reset stall", 64'(stall),  64'(0));
        check("reset hi",    64'(hi_out), 64'(0));
        check("reset lo",    64'(lo_out), 64'(0));
        rst         = 1'b0;
        issue_valid = 1'b0;

        // Table of known products.
        for (int i = 0; i < 7; i++) begin
            run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 0);
            check($sformatf("vec%0d table_hi", i), 64'(hi_out), 64'(vecs[i].hi));
            check($sformatf("vec%0d table_lo", i), 64'(lo_out), 64'(vecs[i].lo));
        end

        // MFHI held from MUL cycle 5: stalls through cycle 32, free in DONE.
        run_mult("mfhi_hold", 32'hFFFF_FFFF, 32'd2, 3);

        // Unrelated funct held through MUL: never stalls, result unaffected.
        run_mult("add_hold", 32'hCAFE_F00D, 32'h1234_5678, 2);

        // Second MULTU held during the first: accepted in DONE.
        issue_valid = 1'b1;
        funct       = FUNCT_MULTU;
        rs_data     = 32'd3;
        rt_data     = 32'd5;
        tick();
        rs_data = 32'd7;
        rt_data = 32'd9;
        #1;
        check("b2b stall_held", 64'(stall), 64'(1));
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b first_done_cycle", 64'(cyc), 64'(DONE_CYCLE));
        check("b2b first_lo", 64'(lo_out), 64'(15));
        check("b2b stall_in_done", 64'(stall), 64'(0));
        tick();
        issue_valid = 1'b0;
        rs_data     = $urandom;
        rt_data     = $urandom;
        check("b2b second_busy", 64'(busy), 64'(1));
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b second_done_cycle", 64'(cyc), 64'(DONE_CYCLE));
        check("b2b second_lo", 64'(lo_out), 64'(63));
        check("b2b second_hi", 64'(hi_out), 64'(0));
        model_hi = 32'd0;
        model_lo = 32'd63;
        tick();

        // Reset at MUL cycle 10 aborts the operation.
        issue_valid = 1'b1;
        funct       = FUNCT_MULTU;
        rs_data     = 32'h1234_5678;
        rt_data     = 32'h9ABC_DEF0;
        tick();
        issue_valid = 1'b0;
        repeat (9) tick();
        check("abort pre_busy", 64'(busy), 64'(1));
        rst         = 1'b1;
        issue_valid = 1'b1;
        funct       = FUNCT_MFLO;
        #1;
        check("abort busy",  64'(busy),   64'(0));
        check("abort done",  64'(done),   64'(0));
        check("abort stall", 64'(stall),  64'(0));
        check("abort hi",    64'(hi_out), 64'(0));
        check("abort lo",    64'(lo_out), 64'(0));
        tick();
        rst         = 1'b0;
        issue_valid = 1'b0;
        model_hi    = '0;
        model_lo    = '0;
        pulses      = 0;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        check("abort no_done", 64'(pulses), 64'(0));
        check("abort hi_after", 64'(hi_out), 64'(0));
        check("abort lo_after", 64'(lo_out), 64'(0));

        // MULTU on the very first edge after reset release.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_mult("post_reset", 32'h1234_5678, 32'h9ABC_DEF0, 0);

        // Randomized operands with random non-MULTU traffic during MUL.
        for (int i = 0; i < 12; i++) begin
            ra = (i % 4 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rb = (i % 5 == 0) ? 32'd0 : 32'($urandom);
            run_mult($sformatf("rand%0d", i), ra, rb, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
